// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   MDU_XLEN     default operand width
//   FN_*         MIPS funct codes recognised by the unit
//   mdu_state_e  sequencer states
//   is_muldiv()  true for the four multi-cycle functs
package mdu_pkg;

  localparam int MDU_XLEN = 32;

  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_e;

  function automatic logic is_muldiv(input logic [5:0] funct);
    return (funct == FN_MULT) || (funct == FN_MULTU) ||
           (funct == FN_DIV)  || (funct == FN_DIVU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: EX-stage <-> MDU request/response bundle.
//   master (EX stage): drives req_valid, req_funct, src_a, src_b, flush;
//                      observes req_ready, stall, done, hi, lo
//   slave  (MDU):      the mirror image
interface mdu_ctrl_if #(parameter int XLEN = mdu_pkg::MDU_XLEN);

  logic            req_valid;
  logic [5:0]      req_funct;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            flush;
  logic            req_ready;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output req_valid, req_funct, src_a, src_b, flush,
    input  req_ready, stall, done, hi, lo
  );

  modport slave (
    input  req_valid, req_funct, src_a, src_b, flush,
    output req_ready, stall, done, hi, lo
  );

endinterface

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: shared 2*XLEN shift register with one adder/subtractor.
//   clk, resetn   clock / async active-low reset
//   load          latch operands (mode selects their placement)
//   step          perform one iteration in the selected mode
//   mode          0 = shift-add multiply, 1 = restoring divide
//   op_a, op_b    magnitudes: multiplicand/multiplier or dividend/divisor
//   product       full 2*XLEN product (multiply)
//   quotient      low half of the register (divide)
//   remainder     high half of the register (divide)
module mdu_iter_core
  import mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              step,
  input  logic              mode,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic [2*XLEN-1:0] product,
  output logic [XLEN-1:0]   quotient,
  output logic [XLEN-1:0]   remainder
);

  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic [XLEN-1:0]   acc_hi;
  logic [XLEN-1:0]   acc_lo;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_trial;

  assign acc_hi = acc[2*XLEN-1:XLEN];
  assign acc_lo = acc[XLEN-1:0];

  // Multiply adds the multiplicand into the upper half when the multiplier
  // LSB is set (carry kept in bit XLEN). Divide subtracts the divisor from
  // the remainder after it has absorbed the next dividend bit; bit XLEN of
  // the difference is the borrow.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_trial = {acc_hi, acc_lo[XLEN-1]} - {1'b0, opnd};
  end

  // Multiply: acc = {partial, multiplier}, shifting right each step.
  // Divide:   acc = {remainder, dividend/quotient}, shifting left each step.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc  <= '0;
      opnd <= '0;
    end else if (load) begin
      acc  <= {{XLEN{1'b0}}, (mode ? op_a : op_b)};
      opnd <= mode ? op_b : op_a;
    end else if (step) begin
      if (!mode)
        acc <= {mul_sum, acc_lo[XLEN-1:1]};
      else if (!div_trial[XLEN])
        acc <= {div_trial[XLEN-1:0], acc_lo[XLEN-2:0], 1'b1};
      else
        acc <= {acc[2*XLEN-2:0], 1'b0};
    end
  end

  assign product   = acc;
  assign quotient  = acc_lo;
  assign remainder = acc_hi;

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
//   clk, resetn   clock / async active-low reset
//   bus (slave)   req_valid/req_funct/src_a/src_b/flush in,
//                 req_ready/stall/done/hi/lo out
// Sequence: accept (E0), XLEN iterations (E1..EXLEN), sign fix-up and HI/LO
// write (EXLEN+1) with a one-cycle done pulse afterwards.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic     clk,
  input  logic     resetn,
  mdu_ctrl_if.slave bus
);

  localparam int CW = $clog2(XLEN);

  mdu_state_e        state;
  logic [CW-1:0]     counter;
  logic              sign_q;
  logic              sign_r;
  logic              op_div;
  logic              done_q;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;

  logic              accept;
  logic              start;
  logic              fn_signed;
  logic              fn_div;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              core_mode;
  logic              core_step;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   quotient;
  logic [XLEN-1:0]   remainder;

  // Request decode and operand magnitudes; unsigned ops pass raw values.
  always_comb begin
    accept    = (state == ST_IDLE) && bus.req_valid && !bus.flush;
    start     = accept && is_muldiv(bus.req_funct);
    fn_signed = (bus.req_funct == FN_MULT) || (bus.req_funct == FN_DIV);
    fn_div    = (bus.req_funct == FN_DIV)  || (bus.req_funct == FN_DIVU);
    mag_a     = (fn_signed && bus.src_a[XLEN-1]) ? -bus.src_a : bus.src_a;
    mag_b     = (fn_signed && bus.src_b[XLEN-1]) ? -bus.src_b : bus.src_b;
    // Mode comes from the funct while loading, from the state afterwards.
    core_mode = (state == ST_IDLE) ? fn_div : (state == ST_DIV);
    core_step = ((state == ST_MUL) || (state == ST_DIV)) && !bus.flush;
  end

  mdu_iter_core #(.XLEN(XLEN)) u_core (
    .clk       (clk),
    .resetn    (resetn),
    .load      (start),
    .step      (core_step),
    .mode      (core_mode),
    .op_a      (mag_a),
    .op_b      (mag_b),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // Sequencer FSM. sign_q/sign_r are forced to 0 for unsigned ops so the
  // fix-up in ST_FIX applies unconditionally. Flush returns to IDLE from any
  // busy state without touching HI/LO.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      counter <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      op_div  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (bus.req_funct == FN_MTHI) begin
              hi_q <= bus.src_a;
            end else if (bus.req_funct == FN_MTLO) begin
              lo_q <= bus.src_a;
            end else if (start) begin
              sign_q  <= fn_signed & (bus.src_a[XLEN-1] ^ bus.src_b[XLEN-1]);
              sign_r  <= fn_signed & bus.src_a[XLEN-1];
              op_div  <= fn_div;
              counter <= '0;
              state   <= fn_div ? ST_DIV : ST_MUL;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (bus.flush) begin
            state   <= ST_IDLE;
            counter <= '0;
          end else begin
            if (counter == CW'(XLEN-1))
              state <= ST_FIX;
            counter <= counter + 1'b1;
          end
        end
        ST_FIX: begin
          if (!bus.flush) begin
            if (op_div) begin
              lo_q <= sign_q ? -quotient  : quotient;
              hi_q <= sign_r ? -remainder : remainder;
            end else begin
              {hi_q, lo_q} <= sign_q ? -product : product;
            end
            done_q <= 1'b1;
          end
          state   <= ST_IDLE;
          counter <= '0;
        end
        default: begin
          state   <= ST_IDLE;
          counter <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready = (state == ST_IDLE);
  assign bus.stall     = (state != ST_IDLE) ||
                         (bus.req_valid && is_muldiv(bus.req_funct) && !bus.flush);
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: scoreboard bench for mdu_ctrl. Requests push their expected
// {hi,lo} from an arithmetic reference model; a monitor pops and compares on
// every done pulse. Directed cases cover timing, div-by-zero, overflow,
// flush, busy MTHI and mid-operation reset; a random phase follows.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  always #5 clk = ~clk;

  mdu_ctrl_if #(.XLEN(XLEN)) bus();

  mdu_ctrl #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [63:0] sb_q[$];
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  logic [5:0]  fn_tab [7] = '{FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
                              FN_MTHI, FN_MTLO, 6'h20};
  logic [31:0] corner_tab [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000,
                                  32'h7FFFFFFF, 32'hFFFFFFF8};

  // Reference: signed/unsigned 64-bit arithmetic; divide by zero yields a
  // raw quotient of all ones and raw remainder |a|, then the sign rules.
  function automatic logic [63:0] refModel(input logic [5:0] fn,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    longint      sa, sb, p;
    logic [31:0] q, r, mag_a;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = '0;
    r  = '0;
    if (fn == FN_MULT) begin
      p = sa * sb;
      return p;
    end else if (fn == FN_MULTU) begin
      return {32'h0, a} * {32'h0, b};
    end else if (fn == FN_DIV) begin
      if (b == 32'h0) begin
        mag_a = a[31] ? -a : a;
        q = a[31] ? -32'hFFFFFFFF : 32'hFFFFFFFF;
        r = a[31] ? -mag_a : mag_a;
      end else begin
        q = 32'(sa / sb);
        r = 32'(sa % sb);
      end
    end else begin
      if (b == 32'h0) begin
        q = 32'hFFFFFFFF;
        r = a;
      end else begin
        q = a / b;
        r = a % b;
      end
    end
    return {r, q};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest request.
  always @(negedge clk) begin
    if (resetn && bus.done) begin
      if (sb_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("[TB] FAIL done_unexpected: got done=1 hi=%h lo=%h expected no done",
                 bus.hi, bus.lo);
      end else begin
        checkOutput("scoreboard_hilo", {bus.hi, bus.lo}, sb_q.pop_front());
      end
    end
  end

  // Present a request, hold it until accepted, record the expectation.
  task automatic applyStimulus(input logic [5:0] fn, input logic [31:0] a,
                               input logic [31:0] b);
    int guard = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_funct = fn;
    bus.src_a     = a;
    bus.src_b     = b;
    while (!bus.req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) begin
      vec_cnt++;
      err_cnt++;
      $display("[TB] FAIL accept_timeout: got req_ready=0 expected 1");
    end
    if (is_muldiv(fn)) begin
      sb_q.push_back(refModel(fn, a, b));
      {model_hi, model_lo} = refModel(fn, a, b);
    end else if (fn == FN_MTHI) begin
      model_hi = a;
    end else if (fn == FN_MTLO) begin
      model_lo = a;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int guard = 0;
    while (sb_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (sb_q.size() != 0) begin
      vec_cnt++;
      err_cnt++;
      $display("[TB] FAIL done_timeout: got %0d pending expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  function automatic logic [31:0] pickOperand();
    if ($urandom_range(0, 2) == 0)
      return corner_tab[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] prev_hi;
    logic [31:0] ra, rb;
    logic [5:0]  rf;
    int          guard;

    bus.req_valid = 1'b0;
    bus.req_funct = '0;
    bus.src_a     = '0;
    bus.src_b     = '0;
    bus.flush     = 1'b0;

    // Reset state
    #12;
    checkOutput("reset_hilo", {bus.hi, bus.lo}, 64'h0);
    checkOutput("reset_done", 64'(bus.done), 64'h0);
    checkOutput("reset_ready", 64'(bus.req_ready), 64'h1);
    checkOutput("reset_stall", 64'(bus.stall), 64'h0);
    @(negedge clk);
    resetn = 1'b1;

    // MULT -3*5 with cycle-exact stall/done checks
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_funct = FN_MULT;
    bus.src_a     = 32'hFFFFFFFD;
    bus.src_b     = 32'd5;
    #1;
    checkOutput("mult_stall_e0", 64'(bus.stall), 64'h1);
    sb_q.push_back(refModel(FN_MULT, 32'hFFFFFFFD, 32'd5));
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      checkOutput("mult_stall_busy", 64'(bus.stall), 64'h1);
      checkOutput("mult_done_early", 64'(bus.done), 64'h0);
    end
    @(negedge clk);
    checkOutput("mult_done_pulse", 64'(bus.done), 64'h1);
    checkOutput("mult_stall_done", 64'(bus.stall), 64'h0);
    checkOutput("mult_hilo", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFF1);
    @(negedge clk);
    checkOutput("mult_done_once", 64'(bus.done), 64'h0);

    // Directed arithmetic cases with literal expectations
    applyStimulus(FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF); waitIdle();
    checkOutput("multu_max", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);
    applyStimulus(FN_DIV, 32'hFFFFFFF9, 32'd2); waitIdle();
    checkOutput("div_neg7_2", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);
    applyStimulus(FN_DIVU, 32'd7, 32'd2); waitIdle();
    checkOutput("divu_7_2", {bus.hi, bus.lo}, 64'h00000001_00000003);
    applyStimulus(FN_DIV, 32'h80000000, 32'hFFFFFFFF); waitIdle();
    checkOutput("div_overflow", {bus.hi, bus.lo}, 64'h00000000_80000000);
    applyStimulus(FN_DIVU, 32'h1234, 32'h0); waitIdle();
    checkOutput("divu_by_zero", {bus.hi, bus.lo}, 64'h00001234_FFFFFFFF);
    checkOutput("divu_by_zero_ready", 64'(bus.req_ready), 64'h1);
    applyStimulus(FN_DIV, 32'hFFFFFFF8, 32'h0); waitIdle();
    checkOutput("div_by_zero", {bus.hi, bus.lo}, 64'hFFFFFFF8_00000001);

    // Flush at E10 of a DIV leaves HI/LO untouched
    applyStimulus(FN_MTHI, 32'hAA, 32'h0);
    applyStimulus(FN_MTLO, 32'hBB, 32'h0);
    @(negedge clk);
    checkOutput("mthi_mtlo", {bus.hi, bus.lo}, 64'h000000AA_000000BB);
    bus.req_valid = 1'b1;
    bus.req_funct = FN_DIV;
    bus.src_a     = 32'd100;
    bus.src_b     = 32'd7;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_ready", 64'(bus.req_ready), 64'h1);
    repeat (40) @(negedge clk);
    checkOutput("flush_hilo", {bus.hi, bus.lo}, 64'h000000AA_000000BB);

    // MTHI presented while busy waits for IDLE
    prev_hi = model_hi;
    applyStimulus(FN_MULTU, 32'd3, 32'd4);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_funct = FN_MTHI;
    bus.src_a     = 32'h55;
    repeat (5) @(negedge clk);
    checkOutput("busy_mthi_ready", 64'(bus.req_ready), 64'h0);
    checkOutput("busy_mthi_hi", 64'(bus.hi), 64'(prev_hi));
    guard = 0;
    while (!bus.req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    model_hi = 32'h55;
    @(negedge clk);
    checkOutput("mthi_after_idle", {bus.hi, bus.lo}, {model_hi, model_lo});

    // Reset pulse at E20 of a MULT
    applyStimulus(FN_MULT, 32'h12345678, 32'h9ABCDEF0);
    repeat (20) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("midreset_hilo", {bus.hi, bus.lo}, 64'h0);
    checkOutput("midreset_done", 64'(bus.done), 64'h0);
    checkOutput("midreset_ready", 64'(bus.req_ready), 64'h1);
    sb_q.delete();
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus(FN_MULT, 32'hFFFF0001, 32'h00012345); waitIdle();

    // Random phase: back-to-back requests, incl. MTHI/MTLO and invalid functs
    for (int i = 0; i < 60; i++) begin
      rf = fn_tab[$urandom_range(0, 6)];
      ra = pickOperand();
      rb = pickOperand();
      applyStimulus(rf, ra, rb);
      if (!is_muldiv(rf)) begin
        @(negedge clk);
        checkOutput("rand_mt_hilo", {bus.hi, bus.lo}, {model_hi, model_lo});
      end
    end
    waitIdle();
    @(negedge clk);
    checkOutput("final_hilo", {bus.hi, bus.lo}, {model_hi, model_lo});

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide sequencer for the EX stage. Owns the HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests, keyed on the same 6-bit MIPS funct field the ALU decoder uses.
- Runs iterative shift-add multiply or restoring divide over 32 cycles, applies a sign fix-up, and writes HI/LO.
- Raises a pipeline stall while busy. Supports flush on exception/branch-kill.

Parameters:
- XLEN, 32, operand width; iteration count equals XLEN.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  EX stage presents an MDU instruction
- req_funct  in  6  MIPS funct: 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU, 0x11 MTHI, 0x13 MTLO
- src_a  in  XLEN  rs value (dividend / multiplicand / MTHI-MTLO data)
- src_b  in  XLEN  rt value (divisor / multiplier)
- flush  in  1  kill in-flight and presented request
- req_ready  out  1  controller can accept (state==IDLE)
- stall  out  1  hold pipeline
- done  out  1  one-cycle pulse: HI/LO just updated by mul/div
- hi  out  XLEN  HI register
- lo  out  XLEN  LO register

Behaviour:
- Reset (async, resetn=0): state=IDLE, hi=0, lo=0, done=0, counter=0, work regs=0.
- States: IDLE, MUL, DIV, FIX.
- Accept: at a rising edge with state==IDLE, req_valid=1 and flush=0.
  - Funct not in the list: ignored.
- MTHI/MTLO: written at the accept edge; no busy, no done, stall=0.
- MULT/MULTU/DIV/DIVU at accept edge E0:
  - Latch |a| and |b| (signed ops) or raw values (unsigned ops).
  - Latch sign_q = sa^sb and sign_r = sa.
  - counter=0; go to MUL or DIV.
- MUL, edges E1..E32: one shift-add step per edge on a 2*XLEN accumulator. counter==XLEN-1 at E32 moves to FIX.
- DIV, edges E1..E32: one restoring step per edge: shift remainder:quotient left, trial subtract divisor, keep if non-negative, set quotient bit. Same exit.
- FIX at E33:
  - Mul: negate the 64-bit product if sign_q (signed op only); write {hi,lo}.
  - Div: lo = sign_q ? -q : q; hi = sign_r ? -r : r.
  - done=1 for the cycle after E33. State returns to IDLE.
- Total latency: new HI/LO and done visible 33 edges after accept. Next request can be accepted at E34.
- stall = (state!=IDLE) | (req_valid & mul/div funct & state==IDLE & ~flush). stall is 0 while done=1.
- req_ready = (state==IDLE); busy requests of any funct (including MTHI/MTLO) wait.
- Divide by zero: no trap. Restoring result is q=0xFFFFFFFF, r=|a|, then the normal fix-up with sb=0 is applied. Example: DIV -8/0 gives lo=0x00000001, hi=0xFFFFFFF8.
- Overflow case DIV 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0. Wrap, no exception.
- Flush while MUL/DIV/FIX: state to IDLE at next edge. hi/lo unchanged, done stays 0, counter cleared.
- Flush has priority over a simultaneous accept.
- resetn low mid-operation: immediate return to reset values.
- All arithmetic is modulo 2^XLEN per half; no saturation.

Decomposition:
- Package mdu_pkg:
  - funct constants (FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MTHI, FN_MTLO)
  - state enum
  - XLEN default
- One sub-module mdu_iter_core: shared 64-bit shift register plus adder/subtractor.
  - Inputs: mode, step enable, load.
  - Outputs: product or quotient/remainder.
- mdu_ctrl holds the FSM, counter, sign bits, fix-up and the HI/LO registers.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> after 33 edges hi=0xFFFFFFFF, lo=0xFFFFFFF1; done high exactly 1 cycle; stall high E0..E33.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x1234; no hang; req_ready returns after done.
- Flush asserted at E10 of a DIV (hi=0xAA, lo=0xBB beforehand) -> hi/lo stay 0xAA/0xBB, done never pulses, req_ready=1 next cycle. MTHI 0x55 presented while busy -> hi=0x55 only after return to IDLE.
- resetn pulsed low at E20 of MULT -> hi=lo=0, done=0, req_ready=1 immediately; new MULT afterwards yields correct result.
